// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Target-side responder for the core's data-memory port. Accepts
//            one load/store at a time, holds it for WAIT wait states, then
//            returns a single-cycle response and stalls the pipeline meanwhile.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH = 1024,  // words of storage, power of 2 (>= 2)
  parameter int WAIT  = 2      // wait states, 0..15
) (
  input  logic        clk,
  input  logic        reset,      // asynchronous, active-low
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int          c_addr_w    = $clog2(DEPTH);
  localparam logic [31:0] c_depth     = 32'(DEPTH);
  localparam logic [3:0]  c_wait_init = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
  localparam logic        c_no_wait   = (WAIT == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic                w_accept;
  logic                w_enter_resp;
  logic                w_write;

  // Access captured at acceptance
  logic                r_we;
  logic [c_addr_w-1:0] r_idx;
  logic [31:0]         r_wdata;
  logic [3:0]          r_be;
  logic                r_err;

  // Access as seen on the edge into RESP (live inputs when WAIT==0)
  logic                w_acc_we;
  logic [c_addr_w-1:0] w_acc_idx;
  logic [31:0]         w_acc_wdata;
  logic [3:0]          w_acc_be;
  logic                w_acc_err;

  logic                w_be_legal;
  logic                w_err_in;

  logic [31:0]         r_mem [DEPTH];
  logic [31:0]         r_resp_rdata;
  logic                r_resp_err;

  // Error evaluation of the request currently on the inputs
  always_comb begin
    w_be_legal = 1'b0;
    case (req_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: w_be_legal = 1'b1;
      default:                   w_be_legal = 1'b0;
    endcase
    w_err_in = (req_addr[1:0] != 2'b00)
            || ({2'b00, req_addr[31:2]} >= c_depth)
            || (req_we && !w_be_legal);
  end

  // Pick live request fields in IDLE (zero-wait path), latched ones otherwise
  always_comb begin
    w_acc_we    = r_we;
    w_acc_idx   = r_idx;
    w_acc_wdata = r_wdata;
    w_acc_be    = r_be;
    w_acc_err   = r_err;
    if (r_state == S_IDLE) begin
      w_acc_we    = req_we;
      w_acc_idx   = req_addr[c_addr_w+1:2];
      w_acc_wdata = req_wdata;
      w_acc_be    = req_be;
      w_acc_err   = w_err_in;
    end
  end

  // Next-state and wait-counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (c_no_wait) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_wait_init;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_enter_resp = (w_state_nxt == S_RESP);
  // Reset level gates the write so an edge during reset never touches storage
  assign w_write      = w_enter_resp && w_acc_we && !w_acc_err && reset;

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the request on acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_idx   <= req_addr[c_addr_w+1:2];
      r_wdata <= req_wdata;
      r_be    <= req_be;
      r_err   <= w_err_in;
    end
  end

  // Byte-lane store into storage; contents survive reset
  always_ff @(posedge clk) begin
    if (w_write) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_be[i]) begin
          r_mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
        end
      end
    end
  end

  // Response data/error registered on the edge into RESP, held afterwards
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_resp_err   <= w_acc_err;
      r_resp_rdata <= (!w_acc_we && !w_acc_err) ? r_mem[w_acc_idx] : 32'd0;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  // Released in RESP so the core advances on the edge that samples the data
  assign busy       = ((r_state == S_IDLE) && req_valid) || (r_state == S_WAIT);

endmodule
`default_nettype wire
